iommu_cfg_rw_sched: RTL and testbench
=====================================

# iommu_cfg_rw_sched

Scheduler between the IOMMU configuration port's AXI-Lite slave channels and the single-ported register interface of the IOMMU register map. Accepts at most one outstanding transaction, arbitrates between a pending write (AW+W) and a pending read (AR) round-robin, and sequences the register access and the AXI-Lite response. Sits between the AXI-Lite slave connector and `iommu_regmap_top`, replacing a plain protocol converter.

## Interface
- `ADDR_WIDTH`, 13, byte-address width of AXI-Lite and register interface
- `DATA_WIDTH`, 64, data width; strobe width is `DATA_WIDTH/8`

- `clk_i`  in  1  clock; all logic on rising edge
- `rst_i`  in  1  reset, synchronous, active-high
- `s_axil_awaddr/awprot/awvalid`  in  ADDR_WIDTH/3/1  write address
- `s_axil_awready`  out  1
- `s_axil_wdata/wstrb/wvalid`  in  DATA_WIDTH/DATA_WIDTH/8/1  write data
- `s_axil_wready`  out  1
- `s_axil_bresp/bvalid`  out  2/1;  `s_axil_bready`  in  1
- `s_axil_araddr/arprot/arvalid`  in  ADDR_WIDTH/3/1  read address
- `s_axil_arready`  out  1
- `s_axil_rdata/rresp/rvalid`  out  DATA_WIDTH/2/1;  `s_axil_rready`  in  1
- `reg_valid_o`  out  1  register access request
- `reg_write_o`  out  1  1 = write, 0 = read
- `reg_addr_o`  out  ADDR_WIDTH
- `reg_wdata_o`  out  DATA_WIDTH
- `reg_wstrb_o`  out  DATA_WIDTH/8
- `reg_ready_i`  in  1  access completes in the cycle `reg_valid_o & reg_ready_i`
- `reg_rdata_i`  in  DATA_WIDTH  read data, valid with `reg_ready_i`
- `reg_error_i`  in  1  access error, valid with `reg_ready_i`

## Operation
- FSM states: IDLE, WR_ACC, WR_RSP, RD_ACC, RD_RSP.
- IDLE: write candidate = `awvalid & wvalid` (AW and W always accepted together, never separately). Read candidate = `arvalid`.
  - Only one candidate: grant it.
  - Both: grant opposite of `last_wr` flag (`last_wr`=1 → read wins). `last_wr` resets to 1, so reads win the first tie.
  - Write grant: `awready = wready = 1` that cycle; latch awaddr, wdata, wstrb, awprot; `last_wr<=1`; → WR_ACC.
  - Read grant: `arready = 1`; latch araddr, arprot; `last_wr<=0`; → RD_ACC.
- WR_ACC/RD_ACC: `reg_valid_o=1`, address/data/strobe from latches, held stable until `reg_ready_i`. On ready: latch `reg_error_i` (and `reg_rdata_i` for reads); → WR_RSP / RD_RSP.
- WR_RSP: `bvalid=1`, `bresp` = 2'b10 (SLVERR) if latched error, else 2'b00. On `bready` → IDLE.
- RD_RSP: `rvalid=1`, `rdata` latched, `rresp` as for bresp. On `rready` → IDLE.
- `reg_wstrb_o` is 0 and `reg_wdata_o` is don't-care for reads; address is passed unmodified (no alignment masking).
- awready/wready/arready are combinational from state and valids; they are never asserted outside IDLE.

## Timing
- Reset values: all ready/valid outputs 0, `bresp=rresp=0`, `rdata=0`, `reg_*` outputs 0, state IDLE, `last_wr=1`.
- Address handshake cycle N → `reg_valid_o` at N+1 → with `reg_ready_i` at N+1, `bvalid`/`rvalid` at N+2. Minimum 3 cycles per transaction; next address handshake earliest in the cycle after the response handshake.
- `reg_ready_i` low stalls in *_ACC indefinitely; no timeout.
- B/R valid and payload held stable until accepted.
- AW valid without W (or W without AW): no handshake; read may be granted meanwhile.
- `rst_i` mid-transaction: next cycle state IDLE, all outputs at reset values; the in-flight transaction is dropped without response.

## Configuration
- `IOMMU_CFG_PROT_CHECK_EN` defined: a granted access whose latched `prot[0]` (privileged) is 0 skips *_ACC (`reg_valid_o` never asserted) and goes directly to *_RSP with SLVERR, `rdata=0`; latency 2 cycles.
- Undefined: prot is ignored; all accesses reach the register interface.

## Test plan
- Write 0x0000_0000_0000_0003 to 0x020, wstrb 0xFF, ready immediate → `reg_valid_o` for 1 cycle with write=1, addr 0x020, bvalid next cycle with bresp 00.
- Read 0x010 with `reg_ready_i` delayed 4 cycles, `reg_rdata_i`=0xDEAD_BEEF → reg_valid_o held 5 cycles stable, rvalid with rdata 0xDEAD_BEEF, rresp 00.
- AW+W and AR valid same cycle after reset → read granted first, write second; repeat tie → alternates R,W,R,W.
- `reg_error_i`=1 on a write, bready held low 3 cycles → bresp 10 and bvalid held 3 cycles, no new arready meanwhile.
- AW valid with W low for 5 cycles while AR valid → read completes; awready stays 0 until W arrives.
- `rst_i` pulsed in WR_ACC → next cycle all outputs 0, no bvalid; with `IOMMU_CFG_PROT_CHECK_EN`, awprot=3'b000 write → no reg_valid_o, bresp 10.

Source files
------------

// File: rtl/iommu_cfg_rw_sched.sv
// AXI-Lite to single-port register scheduler for the IOMMU config port: one outstanding access, round-robin R/W.
// Optional IOMMU_CFG_PROT_CHECK_EN rejects unprivileged accesses (prot[0]=0) with SLVERR without touching registers.
module iommu_cfg_rw_sched #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic [2:0]              s_axil_awprot,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic [2:0]              s_axil_arprot,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,
    output logic [DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready,
    output logic                    reg_valid_o,
    output logic                    reg_write_o,
    output logic [ADDR_WIDTH-1:0]   reg_addr_o,
    output logic [DATA_WIDTH-1:0]   reg_wdata_o,
    output logic [DATA_WIDTH/8-1:0] reg_wstrb_o,
    input  logic                    reg_ready_i,
    input  logic [DATA_WIDTH-1:0]   reg_rdata_i,
    input  logic                    reg_error_i
);

    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WR_ACC, WR_RSP, RD_ACC, RD_RSP} state_t;

    state_t                state_q, state_d;
    logic                  last_wr_q;
    logic                  wr_cand, rd_cand, wr_grant, rd_grant, priv_ok;
    logic [ADDR_WIDTH-1:0] addr_p1;
    logic [DATA_WIDTH-1:0] wdata_p1;
    logic [STRB_W-1:0]     wstrb_p1;
    logic                  err_p2;
    logic [DATA_WIDTH-1:0] rdata_p2;

    function automatic logic [1:0] resp_enc(input logic err);
        return err ? 2'b10 : 2'b00;
    endfunction

    // Round-robin: on a tie the side that did not go last wins; no grant while in reset.
    assign wr_cand  = s_axil_awvalid & s_axil_wvalid;
    assign rd_cand  = s_axil_arvalid;
    assign wr_grant = (state_q == IDLE) & ~rst_i & wr_cand & (~rd_cand | ~last_wr_q);
    assign rd_grant = (state_q == IDLE) & ~rst_i & rd_cand & (~wr_cand | last_wr_q);

`ifdef IOMMU_CFG_PROT_CHECK_EN
    assign priv_ok = wr_grant ? s_axil_awprot[0] : s_axil_arprot[0];
`else
    logic unused_prot;
    assign unused_prot = ^{s_axil_awprot, s_axil_arprot};
    assign priv_ok     = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (wr_grant) last_wr_q <= 1'b1;
            else if (rd_grant) last_wr_q <= 1'b0;
        end
    end

    // Stage 1: request capture at address handshake; stage 2: response capture at register completion.
    always_ff @(posedge clk_i) begin
        if (wr_grant) begin
            addr_p1  <= s_axil_awaddr;
            wdata_p1 <= s_axil_wdata;
            wstrb_p1 <= s_axil_wstrb;
        end else if (rd_grant) begin
            addr_p1 <= s_axil_araddr;
        end
        if ((wr_grant | rd_grant) & ~priv_ok) begin
            err_p2   <= 1'b1;
            rdata_p2 <= '0;
        end else if (reg_valid_o & reg_ready_i) begin
            err_p2 <= reg_error_i;
            if (!reg_write_o) rdata_p2 <= reg_rdata_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wr_grant)      state_d = priv_ok ? WR_ACC : WR_RSP;
                else if (rd_grant) state_d = priv_ok ? RD_ACC : RD_RSP;
            end
            WR_ACC:  if (reg_ready_i)   state_d = WR_RSP;
            RD_ACC:  if (reg_ready_i)   state_d = RD_RSP;
            WR_RSP:  if (s_axil_bready) state_d = IDLE;
            RD_RSP:  if (s_axil_rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Payload outputs are gated by state so stale latches never leak out after reset.
    always_comb begin
        s_axil_awready = wr_grant;
        s_axil_wready  = wr_grant;
        s_axil_arready = rd_grant;
        reg_valid_o    = (state_q == WR_ACC) | (state_q == RD_ACC);
        reg_write_o    = (state_q == WR_ACC);
        reg_addr_o     = reg_valid_o ? addr_p1 : '0;
        reg_wdata_o    = reg_write_o ? wdata_p1 : '0;
        reg_wstrb_o    = reg_write_o ? wstrb_p1 : '0;
        s_axil_bvalid  = (state_q == WR_RSP);
        s_axil_bresp   = s_axil_bvalid ? resp_enc(err_p2) : 2'b00;
        s_axil_rvalid  = (state_q == RD_RSP);
        s_axil_rresp   = s_axil_rvalid ? resp_enc(err_p2) : 2'b00;
        s_axil_rdata   = s_axil_rvalid ? rdata_p2 : '0;
    end

endmodule

// File: tb/tb_iommu_cfg_rw_sched.sv
// Self-checking bench for iommu_cfg_rw_sched: table-driven transactions with a response scoreboard plus hand-written corner sequences.
module tb_iommu_cfg_rw_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] awaddr = '0, araddr = '0, reg_addr;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
    logic        arvalid = 0, arready, rvalid, rready = 0;
    logic [63:0] wdata = '0, rdata, reg_wdata, reg_rdata = '0;
    logic [7:0]  wstrb = '0, reg_wstrb;
    logic [1:0]  bresp, rresp;
    logic        reg_valid, reg_write, reg_ready = 0, reg_error = 0;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        bit          wr;
        logic [12:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [2:0]  prot;
        int          rdy_dly;
        bit          err;
        logic [63:0] rdata;
        int          rsp_dly;
        logic [1:0]  exp_resp;
        logic [63:0] exp_rdata;
    } vec_t;

    typedef struct {
        bit          wr;
        logic [1:0]  resp;
        logic [63:0] rdata;
    } exp_t;

    vec_t tbl[7];
    exp_t sb[$];

    iommu_cfg_rw_sched #(.ADDR_WIDTH(13), .DATA_WIDTH(64)) dut (
        .clk_i(clk), .rst_i(rst),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .reg_valid_o(reg_valid), .reg_write_o(reg_write), .reg_addr_o(reg_addr),
        .reg_wdata_o(reg_wdata), .reg_wstrb_o(reg_wstrb), .reg_ready_i(reg_ready),
        .reg_rdata_i(reg_rdata), .reg_error_i(reg_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " ready"}, {63'd0, awready | wready | arready}, 64'd0);
        chk({nm, " valid"}, {62'd0, bvalid, rvalid}, 64'd0);
        chk({nm, " resp"}, {60'd0, bresp, rresp}, 64'd0);
        chk({nm, " rdata"}, rdata, 64'd0);
        chk({nm, " reg_ctl"}, {62'd0, reg_valid, reg_write}, 64'd0);
        chk({nm, " reg_addr"}, {51'd0, reg_addr}, 64'd0);
        chk({nm, " reg_wdata"}, reg_wdata, 64'd0);
        chk({nm, " reg_wstrb"}, {56'd0, reg_wstrb}, 64'd0);
    endtask

    // Entered and left one time unit after a rising edge with the DUT idle.
    task automatic txn(input vec_t v, input string nm);
        bit   skip;
        exp_t e;
        skip = 1'b0;
`ifdef IOMMU_CFG_PROT_CHECK_EN
        skip = !v.prot[0];
`endif
        if (v.wr) begin
            awaddr = v.addr; awprot = v.prot; wdata = v.wdata; wstrb = v.wstrb;
            awvalid = 1; wvalid = 1;
        end else begin
            araddr = v.addr; arprot = v.prot; arvalid = 1;
        end
        #1;
        if (v.wr) chk({nm, " aw/w ready"}, {62'd0, awready, wready}, 64'd3);
        else      chk({nm, " arready"}, {63'd0, arready}, 64'd1);
        e.wr    = v.wr;
        e.resp  = skip ? 2'b10 : v.exp_resp;
        e.rdata = (v.wr || skip) ? 64'd0 : v.exp_rdata;
        sb.push_back(e);
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        if (!skip) begin
            for (int k = 0; k <= v.rdy_dly; k++) begin
                chk({nm, " reg_valid"}, {63'd0, reg_valid}, 64'd1);
                chk({nm, " reg_write"}, {63'd0, reg_write}, {63'd0, v.wr});
                chk({nm, " reg_addr"}, {51'd0, reg_addr}, {51'd0, v.addr});
                chk({nm, " reg_wstrb"}, {56'd0, reg_wstrb}, v.wr ? {56'd0, v.wstrb} : 64'd0);
                if (v.wr) chk({nm, " reg_wdata"}, reg_wdata, v.wdata);
                chk({nm, " early rsp"}, {62'd0, bvalid, rvalid}, 64'd0);
                if (k == v.rdy_dly) begin
                    reg_ready = 1; reg_error = v.err; reg_rdata = v.rdata;
                end
                tick();
                reg_ready = 0; reg_error = 0; reg_rdata = {$urandom, $urandom};
            end
        end else begin
            chk({nm, " reg_valid skipped"}, {63'd0, reg_valid}, 64'd0);
        end
        for (int k = 0; k <= v.rsp_dly; k++) begin
            if (k < v.rsp_dly) begin
                awvalid = 1; wvalid = 1; arvalid = 1;
            end
            #1;
            chk({nm, " ready in rsp"}, {61'd0, awready, wready, arready}, 64'd0);
            chk({nm, " reg_valid in rsp"}, {63'd0, reg_valid}, 64'd0);
            if (v.wr) begin
                chk({nm, " bvalid"}, {62'd0, bvalid, rvalid}, 64'd2);
                chk({nm, " bresp"}, {62'd0, bresp}, {62'd0, sb[0].resp});
            end else begin
                chk({nm, " rvalid"}, {62'd0, bvalid, rvalid}, 64'd1);
                chk({nm, " rresp"}, {62'd0, rresp}, {62'd0, sb[0].resp});
                chk({nm, " rdata"}, rdata, sb[0].rdata);
            end
            awvalid = 0; wvalid = 0; arvalid = 0;
            if (k == v.rsp_dly) begin
                if (v.wr) bready = 1; else rready = 1;
            end
            tick();
            bready = 0; rready = 0;
        end
        void'(sb.pop_front());
        chk({nm, " rsp retired"}, {62'd0, bvalid, rvalid}, 64'd0);
    endtask

    initial begin
        int grants, last_c;
        tbl[0] = '{1, 13'h020, 64'h3, 8'hFF, 3'b001, 0, 0, 64'h0, 0, 2'b00, 64'h0};
        tbl[1] = '{0, 13'h010, 64'h0, 8'h00, 3'b001, 4, 0, 64'hDEAD_BEEF, 0, 2'b00, 64'hDEAD_BEEF};
        tbl[2] = '{1, 13'h1F8, 64'h0123_4567_89AB_CDEF, 8'h0F, 3'b011, 2, 1, 64'h0, 3, 2'b10, 64'h0};
        tbl[3] = '{0, 13'h1FFF, 64'h0, 8'h00, 3'b001, 0, 1, 64'hCAFE, 2, 2'b10, 64'hCAFE};
        tbl[4] = '{1, 13'h008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h80, 3'b000, 1, 0, 64'h0, 0, 2'b00, 64'h0};
        tbl[5] = '{0, 13'h100, 64'h0, 8'h00, 3'b000, 0, 0, 64'h1111, 1, 2'b00, 64'h1111};
        tbl[6] = '{0, 13'h000, 64'h0, 8'h00, 3'b101, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF};

        rst = 1;
        tick(); tick();
        chk_all_zero("reset");
        rst = 0;
        tick();

        foreach (tbl[i]) txn(tbl[i], $sformatf("vec%0d", i));

        // Write address without data: only the read may proceed.
        awaddr = 13'h030; awprot = 3'b001; awvalid = 1; wvalid = 0;
        araddr = 13'h050; arprot = 3'b001; arvalid = 1;
        #1;
        chk("aw-only arready", {62'd0, arready, awready}, 64'd2);
        tick();
        arvalid = 0; reg_ready = 1; reg_rdata = 64'h55;
        chk("aw-only reg_addr", {51'd0, reg_addr}, 64'h050);
        chk("aw-only awready acc", {62'd0, awready, wready}, 64'd0);
        tick();
        reg_ready = 0; rready = 1;
        chk("aw-only rdata", rdata, 64'h55);
        chk("aw-only awready rsp", {62'd0, awready, wready}, 64'd0);
        tick();
        rready = 0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("aw-only awready idle", {62'd0, awready, wready}, 64'd0);
            tick();
        end
        wdata = 64'h77; wstrb = 8'h01; wvalid = 1;
        #1;
        chk("aw-only w arrives", {62'd0, awready, wready}, 64'd3);
        tick();
        awvalid = 0; wvalid = 0; reg_ready = 1;
        chk("aw-only reg_wdata", reg_wdata, 64'h77);
        tick();
        reg_ready = 0; bready = 1;
        chk("aw-only bvalid", {62'd0, bvalid, bresp[1]}, 64'd2);
        tick();
        bready = 0;

        // Reset while the register access is stalled drops the transaction.
        awaddr = 13'h040; awprot = 3'b001; wdata = 64'h99; wstrb = 8'hFF; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        chk("rst-mid in acc", {63'd0, reg_valid}, 64'd1);
        rst = 1;
        tick();
        chk_all_zero("rst-mid");
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst-mid no rsp", {61'd0, bvalid, rvalid, reg_valid}, 64'd0);
        end

        // Persistent tie right after reset: grants alternate R,W,R,W every 3 cycles.
        awaddr = 13'h060; awprot = 3'b001; wdata = 64'hA; wstrb = 8'hFF;
        araddr = 13'h068; arprot = 3'b001;
        awvalid = 1; wvalid = 1; arvalid = 1; reg_ready = 1; bready = 1; rready = 1;
        grants = 0; last_c = 0;
        for (int c = 0; c < 30 && grants < 4; c++) begin
            #1;
            if (awready | arready) begin
                chk($sformatf("tie grant%0d one-hot", grants), {62'd0, awready, arready}, (grants % 2) ? 64'd2 : 64'd1);
                if (grants > 0) chk($sformatf("tie grant%0d spacing", grants), c - last_c, 64'd3);
                last_c = c;
                grants++;
            end
            tick();
        end
        chk("tie grant count", grants, 64'd4);
        awvalid = 0; wvalid = 0; arvalid = 0;
        tick(); tick(); tick();
        reg_ready = 0; bready = 0; rready = 0;
        #1;
        chk_all_zero("tie drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
